fetch_sequencer: RTL and testbench

- Owns the program counter and sequences the combinational instruction memory (5-bit word address, 32-bit instruction, same-cycle read).
- Feeds fetched instructions to decode through a small in-order buffer with a valid/ready handshake.
- Handles branch/jump redirect with a buffer flush, an enable/halt input, and out-of-range and misaligned PC detection.
- Sits between the PC/branch logic and the IF/ID boundary of the 32-bit pipeline.

---
 rtl/fetch_sequencer_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 85 ++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Holds the NOP encoding, default sizing and the fetch-entry bundle.
package fetch_sequencer_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam int          ADDR_W_DEF   = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer: push/pop/flush, count, full, empty, head.
// Ports: clk, rst_n, flush, push, pop, din -> head, count, full, empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full buffer still accepts a push when the head leaves
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr      <= inc(wr);
      end
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction fetch sequencer feeding decode via a buffer.
// Ports: imem addr/inst, redirect, if_* handshake to decode, sticky faults.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              oob_fault,
  output logic              misalign_fault
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   pc;
  logic          oob;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] cnt;
  logic          unused_cnt;
  fetch_entry_t  wr_e;
  fetch_entry_t  hd_e;

  assign oob        = |pc[31:ADDR_W+2];
  assign imem_addr  = pc[ADDR_W+1:2];
  assign if_valid   = ~empty;
  assign pop        = if_valid & id_ready;
  assign push       = fetch_en & ~redirect_valid
                    & (~full | pop);
  assign wr_e.pc    = pc;
  assign wr_e.inst  = oob ? NOP : imem_inst;
  assign unused_cnt = ^cnt;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (wr_e),
    .head  (hd_e),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign if_inst     = hd_e.inst;
  assign if_pc       = hd_e.pc;
  assign if_pc_plus4 = hd_e.pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      oob_fault      <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_target[31:2], 2'b00};
        if (|redirect_target[1:0]) misalign_fault <= 1'b1;
      end else if (push) begin
        pc <= pc + 32'd4;
        if (oob) oob_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed plan plus random run.
// Reference is a queue-level model of the buffer, PC and fault flags.
module tb_fetch_sequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          fetch_en = 0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_inst;
  logic          redirect_valid = 0;
  logic [31:0]   redirect_target = 0;
  logic          if_valid;
  logic          id_ready = 0;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc_plus4;
  logic          oob_fault;
  logic          misalign_fault;

  logic [31:0] mem [32];
  assign imem_inst = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .id_ready        (id_ready),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .oob_fault       (oob_fault),
    .misalign_fault  (misalign_fault)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q[$];
  logic [31:0] pc_m;
  logic        oob_m;
  logic        mis_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pc_m  = 32'h0;
    oob_m = 1'b0;
    mis_m = 1'b0;
  endtask

  task automatic check_model();
    logic [31:0] exp_addr;
    exp_addr = {27'd0, pc_m[6:2]};
    chk("valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
    chk("imem_addr", {27'd0, imem_addr}, exp_addr);
    chk("oob", {31'd0, oob_fault}, {31'd0, oob_m});
    chk("misalign", {31'd0, misalign_fault}, {31'd0, mis_m});
    if (q.size() > 0) begin
      chk("inst", if_inst, q[0][31:0]);
      chk("pc", if_pc, q[0][63:32]);
      chk("pc4", if_pc_plus4, q[0][63:32] + 32'd4);
    end
  endtask

  // apply inputs at a negedge, advance the model, check at next negedge
  task automatic cyc(input logic fe, input logic rv,
                     input logic [31:0] rt, input logic rdy);
    logic        pop;
    logic        push;
    logic [31:0] inst;
    fetch_en        = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    id_ready        = rdy;
    pop = (q.size() > 0) && rdy;
    if (rv) begin
      q.delete();
      pc_m = {rt[31:2], 2'b00};
      if (rt[1:0] != 2'b00) mis_m = 1'b1;
    end else begin
      push = fe && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (pc_m < 32'd128) begin
          inst = mem[pc_m[6:2]];
        end else begin
          inst  = 32'h0;
          oob_m = 1'b1;
        end
        q.push_back({pc_m, inst});
        pc_m = pc_m + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] rt;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0]  = 32'h2002_0005;
    mem[1]  = 32'h2007_0003;
    mem[2]  = 32'h2003_000c;
    mem[3]  = 32'h00e2_2025;
    mem[15] = 32'hac47_0047;
    model_reset();

    // reset state
    #12;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h4);
    chk("rst_oob", {31'd0, oob_fault}, 32'd0);
    chk("rst_mis", {31'd0, misalign_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, no bubbles
    cyc(1, 0, 0, 1);
    chk("s1_inst", if_inst, 32'h2002_0005);
    chk("s1_pc", if_pc, 32'h0);
    cyc(1, 0, 0, 1);
    chk("s2_inst", if_inst, 32'h2007_0003);
    chk("s2_pc", if_pc, 32'h4);
    cyc(1, 0, 0, 1);
    chk("s3_inst", if_inst, 32'h2003_000c);
    chk("s3_pc", if_pc, 32'h8);

    // backpressure after first instruction
    do_reset();
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("bp_head", if_inst, 32'h2007_0003);
    chk("bp_addr", {27'd0, imem_addr}, 32'd3);
    cyc(1, 0, 0, 1);
    chk("bp_r1", if_inst, 32'h2003_000c);
    cyc(1, 0, 0, 1);
    chk("bp_r2", if_inst, 32'h00e2_2025);

    // redirect while full
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h3C, 1);
    chk("rd_bubble", {31'd0, if_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("rd_inst", if_inst, 32'hac47_0047);
    chk("rd_pc", if_pc, 32'h3C);
    chk("rd_pc4", if_pc_plus4, 32'h40);

    // out-of-range redirect
    cyc(1, 1, 32'h80, 1);
    cyc(1, 0, 0, 0);
    chk("oob_inst", if_inst, 32'h0);
    chk("oob_set", {31'd0, oob_fault}, 32'd1);
    cyc(1, 1, 32'h0, 1);
    cyc(1, 0, 0, 1);
    chk("oob_stick", {31'd0, oob_fault}, 32'd1);

    // misaligned redirect
    cyc(1, 1, 32'h3E, 1);
    cyc(1, 0, 0, 0);
    chk("mis_inst", if_inst, 32'hac47_0047);
    chk("mis_pc", if_pc, 32'h3C);
    chk("mis_set", {31'd0, misalign_fault}, 32'd1);

    // drain with fetch_en low, then reset mid-cycle
    cyc(1, 1, 32'h0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("drain_empty", {31'd0, if_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_inst", if_inst, 32'h0);
    chk("mr_pc", if_pc, 32'h0);
    chk("mr_pc4", if_pc_plus4, 32'h4);
    chk("mr_oob", {31'd0, oob_fault}, 32'd0);
    chk("mr_mis", {31'd0, misalign_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 1);
    chk("mr_inst2", if_inst, 32'h2002_0005);
    chk("mr_pc2", if_pc, 32'h0);

    // wrap around the top of the address space
    cyc(1, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rt = $urandom_range(0, 40) * 4;
        1: rt = $urandom_range(0, 31) * 4 + $urandom_range(0, 3);
        2: rt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: rt = $urandom;
      endcase
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0),
          rt,
          ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
